// File: rtl/fir_coef_load_ctrl.sv
// FIR coefficient load controller.
// A push-button starts a load, and each commit edge writes coef_in to the next bank address.
// After N_TAPS writes the bank is ready, and the FIR delay line is flushed once.
// Sample strobes reach the FIR only while ready and not flushing.
module fir_coef_load_ctrl #(
  parameter int unsigned N_TAPS = 16,
  parameter int unsigned COEF_W = 12
) (
  input  logic              clk_100MHz_i,
  input  logic              rst_i,
  input  logic              pulsador_carga_coef_i,
  input  logic              cambio_coef_i,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              sample_valid_i,
  output logic              coef_we_o,
  output logic [3:0]        coef_addr_o,
  output logic [COEF_W-1:0] coef_data_o,
  output logic [4:0]        coef_count_o,
  output logic              load_busy_o,
  output logic              coef_ready_o,
  output logic              fir_flush_o,
  output logic              fir_sample_valid_o
);

  localparam logic [4:0] TapsN    = 5'(N_TAPS);
  localparam logic [3:0] LastAddr = 4'(N_TAPS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StReady} state_t;

  // Synchronizer stage [0] is the metastability flop; stage [1] is the first safe copy.
  logic [1:0] r_ld_sync, r_cm_sync;
  logic       r_ld_prev, r_cm_prev;
  // Arm flags block an edge until the input has been seen low after reset.
  logic       r_ld_arm, r_cm_arm;
  logic       r_warm;
  logic       r_load_ev, r_commit_ev;

  state_t              r_state;
  logic [4:0]          r_cnt;
  logic                r_we;
  logic [3:0]          r_addr;
  logic [COEF_W-1:0]   r_data;
  logic                r_flush;
  logic                r_sv;

  // Synchronize both asynchronous inputs and turn rising edges into one-cycle events.
  always_ff @(posedge clk_100MHz_i) begin
    if (rst_i) begin
      r_ld_sync   <= '0;
      r_cm_sync   <= '0;
      r_ld_prev   <= 1'b0;
      r_cm_prev   <= 1'b0;
      r_ld_arm    <= 1'b0;
      r_cm_arm    <= 1'b0;
      r_warm      <= 1'b0;
      r_load_ev   <= 1'b0;
      r_commit_ev <= 1'b0;
    end else begin
      r_ld_sync   <= {r_ld_sync[0], pulsador_carga_coef_i};
      r_cm_sync   <= {r_cm_sync[0], cambio_coef_i};
      r_ld_prev   <= r_ld_sync[1];
      r_cm_prev   <= r_cm_sync[1];
      // Stage [0] holds real input data only from the second edge after reset onward.
      r_warm      <= 1'b1;
      r_ld_arm    <= r_ld_arm | (r_warm & ~r_ld_sync[0]);
      r_cm_arm    <= r_cm_arm | (r_warm & ~r_cm_sync[0]);
      r_load_ev   <= r_ld_sync[1] & ~r_ld_prev & r_ld_arm;
      r_commit_ev <= r_cm_sync[1] & ~r_cm_prev & r_cm_arm;
    end
  end

  // Load FSM with registered write port, flush pulse and delayed sample strobe.
  always_ff @(posedge clk_100MHz_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_flush <= 1'b0;
      r_sv    <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_flush <= 1'b0;
      r_sv    <= sample_valid_i;
      case (r_state)
        StIdle: begin
          if (r_load_ev) begin
            r_state <= StLoad;
            r_cnt   <= '0;
          end
        end
        StLoad: begin
          // A restart takes priority over a coincident commit.
          if (r_load_ev) begin
            r_cnt <= '0;
          end else begin
            if (r_commit_ev && (r_cnt < TapsN)) begin
              r_we   <= 1'b1;
              r_addr <= r_cnt[3:0];
              r_data <= coef_in;
              r_cnt  <= r_cnt + 5'd1;
            end
            // Enter READY on the edge after the last address is written.
            if (r_we && (r_addr == LastAddr)) begin
              r_state <= StReady;
              r_flush <= 1'b1;
            end
          end
        end
        StReady: begin
          if (r_load_ev) begin
            r_state <= StLoad;
            r_cnt   <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign coef_we_o          = r_we;
  assign coef_addr_o        = r_addr;
  assign coef_data_o        = r_data;
  assign coef_count_o       = r_cnt;
  assign load_busy_o        = (r_state == StLoad);
  assign coef_ready_o       = (r_state == StReady);
  assign fir_flush_o        = r_flush;
  assign fir_sample_valid_o = r_sv & (r_state == StReady) & ~r_flush;

endmodule

// File: tb/tb_fir_coef_load_ctrl.sv
// Scoreboard bench for fir_coef_load_ctrl.
// The stimulus side keeps an event-level model of the load.
// It pushes expected writes and sample strobes into queues.
// A monitor on the falling edge pops these entries and compares them against what the DUT presents.
module tb_fir_coef_load_ctrl;
  localparam int N = 16;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         puls;
  logic         camb;
  logic [W-1:0] coef_in;
  logic         sv;
  logic         coef_we_o;
  logic [3:0]   coef_addr_o;
  logic [W-1:0] coef_data_o;
  logic [4:0]   coef_count_o;
  logic         load_busy_o;
  logic         coef_ready_o;
  logic         fir_flush_o;
  logic         fir_sample_valid_o;

  fir_coef_load_ctrl #(.N_TAPS(N), .COEF_W(W)) dut (
    .clk_100MHz_i          (clk),
    .rst_i                 (rst),
    .pulsador_carga_coef_i (puls),
    .cambio_coef_i         (camb),
    .coef_in               (coef_in),
    .sample_valid_i        (sv),
    .coef_we_o             (coef_we_o),
    .coef_addr_o           (coef_addr_o),
    .coef_data_o           (coef_data_o),
    .coef_count_o          (coef_count_o),
    .load_busy_o           (load_busy_o),
    .coef_ready_o          (coef_ready_o),
    .fir_flush_o           (fir_flush_o),
    .fir_sample_valid_o    (fir_sample_valid_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; int data; int at;} wr_t;
  wr_t wq[$];
  int  svq[$];

  // Event-level model: loading flag, ready flag, writes done in the current load.
  bit m_loading = 0;
  bit m_ready   = 0;
  int m_idx     = 0;
  int flush_exp = 0;
  int flush_seen = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops and compares on every write strobe and every gated sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (coef_we_o) begin
        chk("write_expected", (wq.size() > 0) ? 1 : 0, 1);
        if (wq.size() > 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", int'(coef_addr_o), e.addr);
          chk("wr_data", int'(coef_data_o), e.data);
          chk("wr_cycle", cyc, e.at);
        end
      end
      if (fir_flush_o) flush_seen++;
      if (fir_sample_valid_o) begin
        chk("sample_expected", (svq.size() > 0) ? 1 : 0, 1);
        if (svq.size() > 0) chk("sample_cycle", cyc, svq.pop_front());
      end
    end
  end

  task automatic load_pulse(input int hold);
    @(negedge clk);
    puls      = 1'b1;
    m_loading = 1;
    m_ready   = 0;
    m_idx     = 0;
    repeat (hold) @(negedge clk);
    puls = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  task automatic commit_pulse(input logic [W-1:0] d, input int hold);
    @(negedge clk);
    coef_in = d;
    camb    = 1'b1;
    if (m_loading && m_idx < N) begin
      wq.push_back('{m_idx, int'(d), cyc + 4});
      m_idx++;
      if (m_idx == N) begin
        m_loading = 0;
        m_ready   = 1;
        flush_exp++;
      end
    end
    repeat (hold) @(negedge clk);
    camb = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  // Both buttons rise together: the restart wins, so no write is expected.
  task automatic both_pulse(input int hold);
    @(negedge clk);
    coef_in   = W'($urandom);
    puls      = 1'b1;
    camb      = 1'b1;
    m_loading = 1;
    m_ready   = 0;
    m_idx     = 0;
    repeat (hold) @(negedge clk);
    puls = 1'b0;
    camb = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  task automatic strobe();
    @(posedge clk);
    #1;
    sv = 1'b1;
    if (m_ready) svq.push_back(cyc + 1);
    @(posedge clk);
    #1;
    sv = 1'b0;
    repeat ($urandom_range(1, 4)) @(posedge clk);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, int'(load_busy_o), int'(m_loading));
    chk({tag, "_ready"}, int'(coef_ready_o), int'(m_ready));
    chk({tag, "_count"}, int'(coef_count_o), m_idx);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, int'(coef_we_o), 0);
    chk({tag, "_addr"}, int'(coef_addr_o), 0);
    chk({tag, "_data"}, int'(coef_data_o), 0);
    chk({tag, "_count"}, int'(coef_count_o), 0);
    chk({tag, "_busy"}, int'(load_busy_o), 0);
    chk({tag, "_ready"}, int'(coef_ready_o), 0);
    chk({tag, "_flush"}, int'(fir_flush_o), 0);
    chk({tag, "_fsv"}, int'(fir_sample_valid_o), 0);
  endtask

  int coefs [N] = '{-99, 65, 136, 33, -156, -86, 376, 854, 854, 376, -86, -156, 33, 136, 65, -99};

  initial begin
    rst = 1'b1; puls = 1'b0; camb = 1'b0; coef_in = '0; sv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Gating in IDLE, then a full load at 8680 ns spacing.
    repeat (3) strobe();
    load_pulse(434);
    check_state("load_start");
    repeat (2) strobe();
    for (int i = 0; i < N; i++) commit_pulse(W'(coefs[i]), 434);
    check_state("full_load");
    chk("flush_count_full", flush_seen, flush_exp);
    chk("writes_drained_full", wq.size(), 0);
    repeat (4) strobe();

    // Restart after 5 writes; READY only after 16 more.
    load_pulse(10);
    check_state("reload");
    for (int i = 0; i < 5; i++) commit_pulse(W'($urandom), 10);
    check_state("five_writes");
    load_pulse(10);
    check_state("restart");
    for (int i = 0; i < N - 1; i++) commit_pulse(W'($urandom), 10);
    strobe();
    check_state("fifteen_writes");
    commit_pulse(W'($urandom), 10);
    check_state("restart_full");
    repeat (3) strobe();

    // Coincident restart and commit.
    load_pulse(10);
    for (int i = 0; i < 3; i++) commit_pulse(W'($urandom), 10);
    both_pulse(10);
    check_state("coincide");
    commit_pulse(W'($urandom), 10);
    check_state("after_coincide");

    // Reset at write 9, then commits in IDLE must not write.
    for (int i = 0; i < 8; i++) commit_pulse(W'($urandom), 10);
    @(negedge clk);
    rst = 1'b1;
    m_loading = 0; m_ready = 0; m_idx = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midload_reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) commit_pulse(W'($urandom), 10);
    strobe();
    check_state("idle_commits");

    // Button held through reset release must not start a load.
    @(negedge clk);
    rst  = 1'b1;
    puls = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_state("held_through_reset");
    puls = 1'b0;
    repeat (10) @(negedge clk);
    load_pulse(10);
    check_state("load_after_held");

    // Random partial and complete loads.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = (r == 2) ? N : int'($urandom_range(1, N));
      load_pulse(int'($urandom_range(6, 12)));
      for (int i = 0; i < n; i++) commit_pulse(W'($urandom), int'($urandom_range(6, 12)));
      check_state("random_load");
      repeat (2) strobe();
    end

    repeat (10) @(negedge clk);
    chk("flush_count_final", flush_seen, flush_exp);
    chk("writes_drained", wq.size(), 0);
    chk("samples_drained", svq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
